branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- Fetch looks up the PC and gets a predicted direction and next PC.
- The EX stage returns the resolved outcome (the taken bit computed from the ALU flags) and the actual target. This block trains the table on that outcome and reports mispredictions to the hazard/flush logic.
- Relation to branch resolution: resolution decides the outcome late; this block guesses it early.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, at least 2.
- IDX_W, 4, log2(ENTRIES); index taken from PC[IDX_W+1:2].
- CNT_INIT, 2'b01, counter value written on reset and on a not-taken allocation.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_pc  input  32  fetch PC to look up.
- pred_hit  output  1  valid entry with matching tag at if_pc (combinational).
- pred_taken  output  1  predicted taken (combinational).
- pred_target  output  32  predicted next PC (combinational).
- upd_valid  input  1  EX stage holds a resolved conditional branch this cycle.
- upd_pc  input  32  PC of the resolving branch.
- upd_taken  input  1  resolved direction.
- upd_target  input  32  resolved taken target (PC + B-immediate).
- upd_pred_taken  input  1  prediction made for this branch, carried down the pipeline.
- upd_pred_target  input  32  predicted next PC, carried down the pipeline.
- mispredict  output  1  resolved next PC differs from the predicted next PC (combinational).
- correct_pc  output  32  redirect PC: upd_target if upd_taken, else upd_pc+4.
- branch_count  output  32  resolved branches since reset.
- mispred_count  output  32  mispredictions since reset.

Behaviour:
- Entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], ctr[1:0].
- Reset (rst=0, asynchronous):
  - every valid=0, ctr=CNT_INIT, target=0;
  - branch_count=0, mispred_count=0.
  - Reset asserted mid-update discards that update.
- Combinational outputs under reset follow the reset table state: pred_hit=0, pred_taken=0, pred_target=if_pc+4, mispredict=0 when upd_valid=0.
- Lookup (combinational, zero latency):
  - pred_hit = valid[i] & (tag[i] == if_pc tag bits), where i = if_pc[IDX_W+1:2].
  - pred_taken = pred_hit & ctr[i][1].
  - pred_target = pred_taken ? target[i] : if_pc+4 (32-bit wrap).
- Resolution (combinational, only when upd_valid=1; otherwise mispredict=0):
  - mispredict = (upd_taken != upd_pred_taken) | (upd_taken & (upd_pred_target != upd_target)).
  - correct_pc is always driven as defined in Ports.
- Update (rising edge when upd_valid=1), with j = upd_pc index:
  - Hit at j (valid and tag match):
    - ctr saturating: taken increments, capped at 2'b11; not-taken decrements, floored at 2'b00.
    - If taken, target[j] = upd_target.
    - Tag and valid are unchanged.
  - Miss at j (invalid or tag mismatch): allocate, evicting any prior entry.
    - valid=1, tag=upd_pc tag bits, target=upd_target.
    - ctr = upd_taken ? 2'b10 : CNT_INIT.
  - branch_count increments by 1.
  - mispred_count increments by 1 when mispredict=1.
  - Both counters saturate at 32'hFFFFFFFF and do not wrap.
- Simultaneous lookup and update to the same index in one cycle: the lookup sees pre-edge contents, with no bypass. The update becomes visible to a lookup on the following cycle.
- upd_valid=0: table and counters hold.
- if_pc[1:0] and upd_pc[1:0] are ignored.
- Only one update per cycle. Stalling and flushing fetch are the pipeline's responsibility; this block has no stall input.

Test Plan:
- Reset check: assert rst=0 for 2 cycles, then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; branch_count=0, mispred_count=0.
- Cold miss: update pc=0x100, taken=1, target=0x80, pred_taken=0 -> mispredict=1 and correct_pc=0x80. Next cycle, lookup 0x100 -> hit=1, taken=1 (ctr=10), target=0x80; mispred_count=1.
- Counter saturation on a hit entry: 3 taken updates -> ctr=11. Then one not-taken -> lookup still predicts taken. Second not-taken -> ctr=01, predicts not-taken, pred_target=0x104.
- Aliasing: entry at 0x100, then update pc=0x140 (same index when ENTRIES=16), not-taken -> lookup 0x100 misses. Lookup 0x140 hits with pred_taken=0.
- Target mismatch: upd_taken=1, upd_pred_taken=1, upd_pred_target=0x80, upd_target=0x90 -> mispredict=1, correct_pc=0x90; table target becomes 0x90.
- Same-cycle update and lookup at index j: the lookup returns old data; the next cycle returns new data. Asserting rst mid-stream clears all hits immediately, asynchronously, before the next edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry. Lookup is combinational; training from the
// EX-stage resolution happens on the rising edge.
module branch_predictor #(
  parameter int          ENTRIES  = 16,
  parameter int          IDX_W    = 4,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispred_count
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0]            valid;
  logic [ENTRIES-1:0][TAG_W-1:0] tag;
  logic [ENTRIES-1:0][31:0]      target;
  logic [ENTRIES-1:0][1:0]       ctr;

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             upd_hit;
  logic [1:0]       ctr_nxt;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Fetch lookup: reads pre-edge table contents, no bypass from the update port.
  always_comb begin
    pred_hit    = valid[if_idx] & (tag[if_idx] == if_tag);
    pred_taken  = pred_hit & ctr[if_idx][1];
    pred_target = pred_taken ? target[if_idx] : (if_pc + 32'd4);
  end

  // Resolution check against the prediction carried down the pipe.
  always_comb begin
    correct_pc = upd_taken ? upd_target : (upd_pc + 32'd4);
    mispredict = upd_valid &
                 ((upd_taken != upd_pred_taken) |
                  (upd_taken & (upd_pred_target != upd_target)));
  end

  // Next counter value for the entry being trained (hit) or allocated (miss).
  always_comb begin
    upd_hit = valid[upd_idx] & (tag[upd_idx] == upd_tag);
    ctr_nxt = ctr[upd_idx];
    if (!upd_hit)
      ctr_nxt = upd_taken ? 2'b10 : CNT_INIT;
    else if (upd_taken && ctr[upd_idx] != 2'b11)
      ctr_nxt = ctr[upd_idx] + 2'b01;
    else if (!upd_taken && ctr[upd_idx] != 2'b00)
      ctr_nxt = ctr[upd_idx] - 2'b01;
  end

  // Table training: allocate on miss, train counter/target on hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= CNT_INIT;
      end
    end else if (upd_valid) begin
      ctr[upd_idx] <= ctr_nxt;
      if (!upd_hit) begin
        valid[upd_idx]  <= 1'b1;
        tag[upd_idx]    <= upd_tag;
        target[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        target[upd_idx] <= upd_target;
      end
    end
  end

  // Saturating event counters for resolved branches and mispredictions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count  <= '0;
      mispred_count <= '0;
    end else if (upd_valid) begin
      if (branch_count != 32'hFFFF_FFFF)
        branch_count <= branch_count + 32'd1;
      if (mispredict && mispred_count != 32'hFFFF_FFFF)
        mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios followed by random traffic,
// all checked against an abstract table model held in the bench.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic        clk, rst;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispredict;
  logic [31:0] correct_pc, branch_count, mispred_count;

  branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .CNT_INIT(2'b01)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict),
    .correct_pc(correct_pc), .branch_count(branch_count),
    .mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one record per slot, counter kept as a plain int 0..3.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  longint      m_bcnt, m_mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_bcnt = 0; m_mcnt = 0;
  endtask

  task automatic m_lookup(input logic [31:0] pc, output bit hit, output bit tk,
                          output logic [31:0] nxt);
    int s = slot(pc);
    hit = m_valid[s] && (m_tag[s] == tagof(pc));
    tk  = hit && (m_ctr[s] >= 2);
    nxt = tk ? m_tgt[s] : pc + 32'd4;
  endtask

  function automatic bit m_mispred(input bit tk, input logic [31:0] tgt,
                                   input bit ptk, input logic [31:0] ptgt);
    logic [31:0] actual_nxt_taken = tgt;
    if (tk != ptk) return 1;
    return tk && (ptgt != actual_nxt_taken);
  endfunction

  task automatic m_train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input bit mp);
    int s = slot(pc);
    if (m_valid[s] && m_tag[s] == tagof(pc)) begin
      m_ctr[s] = tk ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3) : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
      if (tk) m_tgt[s] = tgt;
    end else begin
      m_valid[s] = 1; m_tag[s] = tagof(pc); m_tgt[s] = tgt; m_ctr[s] = tk ? 2 : 1;
    end
    m_bcnt++;
    if (mp) m_mcnt++;
  endtask

  // One cycle: drive lookup + optional update, check comb outputs, then counters.
  task automatic step(input bit v, input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                      input bit ptk, input logic [31:0] ptgt, input logic [31:0] ipc);
    bit hit, ptaken, mp;
    logic [31:0] nxt;
    @(negedge clk);
    if_pc = ipc; upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
    #1;
    m_lookup(ipc, hit, ptaken, nxt);
    mp = v && m_mispred(tk, tgt, ptk, ptgt);
    chk("pred_hit", {31'd0, pred_hit}, {31'd0, hit});
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, ptaken});
    chk("pred_target", pred_target, nxt);
    chk("mispredict", {31'd0, mispredict}, {31'd0, mp});
    chk("correct_pc", correct_pc, tk ? tgt : pc + 32'd4);
    @(posedge clk);
    if (v) m_train(pc, tk, tgt, mp);
    #1;
    chk("branch_count", branch_count, m_bcnt[31:0]);
    chk("mispred_count", mispred_count, m_mcnt[31:0]);
    upd_valid = 1'b0;
  endtask

  // Lookup-only probe with hand-derived expected values.
  task automatic look(input string tag, input logic [31:0] ipc, input bit eh, input bit et,
                      input logic [31:0] enxt);
    @(negedge clk);
    if_pc = ipc; upd_valid = 1'b0;
    #1;
    chk({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, eh});
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, et});
    chk({tag, "_target"}, pred_target, enxt);
  endtask

  initial begin
    logic [31:0] pc, tgt, ptgt;
    bit tk, ptk, hit;
    rst = 1'b0; if_pc = 32'h100; upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hit", {31'd0, pred_hit}, 32'd0);
    chk("rst_mispred", {31'd0, mispredict}, 32'd0);
    @(negedge clk); rst = 1'b1;
    look("reset", 32'h100, 0, 0, 32'h104);
    chk("rst_bcnt", branch_count, 32'd0);
    chk("rst_mcnt", mispred_count, 32'd0);

    // Cold miss, taken, predicted not-taken.
    step(1, 32'h100, 1, 32'h80, 0, 32'h104, 32'h100);
    chk("cold_mispred_count", mispred_count, 32'd1);
    look("cold", 32'h100, 1, 1, 32'h80);

    // Saturate high, then walk down.
    repeat (3) step(1, 32'h100, 1, 32'h80, 1, 32'h80, 32'h0);
    step(1, 32'h100, 0, 32'h80, 1, 32'h80, 32'h0);
    look("sat_nt1", 32'h100, 1, 1, 32'h80);
    step(1, 32'h100, 0, 32'h80, 1, 32'h80, 32'h0);
    look("sat_nt2", 32'h100, 1, 0, 32'h104);

    // Aliasing: 0x140 evicts 0x100.
    step(1, 32'h140, 0, 32'h500, 0, 32'h144, 32'h0);
    look("alias_old", 32'h100, 0, 0, 32'h104);
    look("alias_new", 32'h140, 1, 0, 32'h144);

    // Taken target mismatch.
    step(1, 32'h140, 1, 32'h90, 1, 32'h80, 32'h0);
    look("tgt_fix", 32'h140, 1, 1, 32'h90);

    // Same-cycle lookup and update: lookup sees pre-edge (miss).
    step(1, 32'h200, 1, 32'h300, 0, 32'h204, 32'h200);
    look("bypass_next", 32'h200, 1, 1, 32'h300);

    // Random traffic over a small PC pool to force hits, aliasing and saturation.
    for (int n = 0; n < 400; n++) begin
      pc  = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      tk  = 1'($urandom);
      tgt = {$urandom_range(0, 15), 2'b00};
      if ($urandom_range(0, 3) != 0) begin
        m_lookup(pc, hit, ptk, ptgt);
      end else begin
        ptk = 1'($urandom); ptgt = {$urandom_range(0, 15), 2'b00};
      end
      step(1'($urandom_range(0, 4) != 0), pc, tk, tgt, ptk, ptgt,
           {24'd0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)});
    end

    // Asynchronous reset mid-update: hits vanish before the next edge, update dropped.
    step(1, 32'h200, 1, 32'h300, 1, 32'h300, 32'h0);
    @(negedge clk);
    if_pc = 32'h200; upd_valid = 1; upd_pc = 32'h200; upd_taken = 1;
    upd_target = 32'h340; upd_pred_taken = 0; upd_pred_target = 32'h204;
    #1;
    chk("pre_rst_hit", {31'd0, pred_hit}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_hit", {31'd0, pred_hit}, 32'd0);
    chk("async_rst_target", pred_target, 32'h204);
    chk("async_rst_bcnt", branch_count, 32'd0);
    @(posedge clk); #1;
    m_reset();
    chk("rst_drop_bcnt", branch_count, 32'd0);
    @(negedge clk); upd_valid = 0; rst = 1'b1;
    look("post_rst", 32'h200, 0, 0, 32'h204);
    step(1, 32'h100, 0, 32'h80, 0, 32'h104, 32'h100);
    look("post_rst_alloc", 32'h100, 1, 0, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
